arm_bus_sequencer: RTL
======================

Name: arm_bus_sequencer

Overview:
Sequences ARM926 external-bus cycles from the CPLD chip-select-5 window (AS, RS, WS, BE, A, D) into single-cycle local register-file transactions on the FPGA clock. Synchronizes the asynchronous strobes and decodes the address window. Issues one read or write request to the user register logic and waits for its acknowledge. Then drives the bus data and the DTACK handshake back to the ARM. A watchdog guarantees every claimed cycle terminates.

Parameters:
BASE_ADDR, 24'h000000, window base; cycle claimed when (ADDR & ADDR_MASK) == BASE_ADDR
ADDR_MASK, 24'hFFF000, window decode mask
REG_AW, 8, local word-address width; reg_addr = ADDR[REG_AW+1:2]
TIMEOUT, 255, max cycles in WAIT before forced completion (1..65535)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
CLK  in  1  FPGA clock (100 MHz)
RST  in  1  asynchronous, active-low reset
AS_N  in  1  address strobe, active-low, asynchronous
RS_N  in  1  read strobe, active-low, asynchronous
WS_N  in  1  write strobe, active-low, asynchronous
BE_N  in  4  byte enables, active-low
ADDR  in  24  ARM byte address
DIN  in  32  ARM write data
DOUT  out  32  read data to ARM bus
DOUT_OE  out  1  high = FPGA drives ARM_D
DTACK_N  out  1  transfer acknowledge, active-low
reg_addr  out  REG_AW  local word address
reg_be  out  4  byte enables, active-high (~BE_N)
reg_wdata  out  32  write data
reg_wr  out  1  one-cycle write request
reg_rd  out  1  one-cycle read request
reg_rdata  in  32  read data, valid with reg_ack
reg_ack  in  1  user acknowledge
err  out  1  sticky error flag (timeout or RS&WS conflict)
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (RST low, async): all sync flops = 1; state = IDLE; DOUT = 0, DOUT_OE = 0, DTACK_N = 1, reg_wr = reg_rd = 0, reg_addr/reg_be/reg_wdata = 0, err = 0, counter = 0.
- Synchronizers: AS_N, RS_N and WS_N each pass through 2 flops. The FSM uses only the synchronized copies (as_s, rs_s, ws_s).
- ADDR, BE_N and DIN are sampled directly on the edge that leaves IDLE. The ARM holds them stable for the whole strobe.
- States: IDLE, WAIT, DONE, RELEASE.
- IDLE, as_s low, window hit, ws_s low, rs_s high:
  - latch reg_addr, reg_be and reg_wdata;
  - reg_wr = 1 for exactly one cycle;
  - go to WAIT.
- IDLE, as_s low, window hit, rs_s low, ws_s high: latch reg_addr and reg_be; reg_rd = 1 for one cycle; go to WAIT.
- IDLE, as_s low, rs_s low and ws_s low, window hit: no request issued; err = 1; go to RELEASE; DTACK is never asserted.
- IDLE, window miss: go to RELEASE silently; DTACK_N stays 1 and DOUT_OE stays 0.
- Latency: reg_wr/reg_rd is high in the cycle after the 3rd rising edge that samples the strobe low. 2 edges go to synchronization and 1 edge registers the request.
- WAIT: reg_ack is sampled from the first WAIT cycle, so an ack coincident with the request pulse is legal.
  - On ack: DOUT = reg_rdata (reads only), counter cleared, go to DONE.
  - Counter increments each WAIT cycle. When counter reaches TIMEOUT with no ack: DOUT = ERR_DATA (reads), err = 1, go to DONE.
  - A reg_ack outside WAIT is ignored.
- DONE: DTACK_N = 0; DOUT_OE = 1 only for reads. Hold until as_s, rs_s and ws_s are all high, then DTACK_N = 1, DOUT_OE = 0, go to IDLE. DTACK_N falls on the edge after ack is sampled.
- RELEASE: outputs idle; wait until as_s, rs_s and ws_s are all high, then go to IDLE. This gives exactly one transaction per bus cycle.
- Back-to-back cycles: a new cycle is recognized only after a full strobe release has been observed.
- err: set by timeout or conflict. err_clr clears it; set wins when both occur in the same cycle.
- Reset mid-transaction: immediate return to the reset values. A pending user request is abandoned, and no reg_wr/reg_rd pulse occurs after reset deasserts until a new strobe is seen.

Test Plan:
- Write: ADDR = 24'h000010, DIN = 32'h12345678, BE_N = 4'b1100, WS_N/AS_N low, user ack 2 cycles after reg_wr -> reg_wr is a single pulse with reg_addr = 4, reg_be = 4'b0011, reg_wdata = 32'h12345678; DTACK_N low on the edge after ack; DTACK_N high 3 edges after strobes release; DOUT_OE stays 0.
- Read with same-cycle ack: ADDR = 24'h000020, reg_rdata = 32'hCAFEF00D, reg_ack tied to reg_rd -> DOUT = 32'hCAFEF00D, DOUT_OE = 1, DTACK_N = 0 until release; reg_rd is exactly one cycle wide.
- Timeout: TIMEOUT = 8, read with reg_ack held 0 -> DTACK_N low after 8 WAIT cycles, DOUT = 32'hDEADBEEF, err = 1; err_clr pulse -> err = 0.
- Out-of-window: ADDR = 24'h001000 -> no reg_wr/reg_rd, DTACK_N stays 1 and DOUT_OE stays 0 for the whole cycle; the next in-window cycle completes normally.
- Conflict: RS_N and WS_N both low in-window -> err = 1, no request, no DTACK; the FSM returns to IDLE after release.
- Reset mid-WAIT: assert RST low during WAIT -> DTACK_N = 1, DOUT_OE = 0 immediately; after RST high with strobes high, no request pulses occur and the following write completes normally.

Source files
------------

// File: rtl/arm_bus_sequencer.sv
// ARM926 CS5 bus cycle sequencer: synchronizes AS/RS/WS, decodes the
// address window and turns each bus cycle into one local rd/wr request.
// Ports: CLK/RST (async active-low); ARM side AS_N, RS_N, WS_N, BE_N,
//   ADDR, DIN in and DOUT, DOUT_OE, DTACK_N out; register side reg_addr,
//   reg_be, reg_wdata, reg_wr, reg_rd out and reg_rdata, reg_ack in;
//   err sticky flag out with err_clr in.
module arm_bus_sequencer #(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter logic [23:0] ADDR_MASK = 24'hFFF000,
    parameter int          REG_AW    = 8,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AS_N,
    input  logic              RS_N,
    input  logic              WS_N,
    input  logic [3:0]        BE_N,
    input  logic [23:0]       ADDR,
    input  logic [31:0]       DIN,
    output logic [31:0]       DOUT,
    output logic              DOUT_OE,
    output logic              DTACK_N,
    output logic [REG_AW-1:0] reg_addr,
    output logic [3:0]        reg_be,
    output logic [31:0]       reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_ack,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_as_sy, r_rs_sy, r_ws_sy;
    logic              r_is_rd, w_is_rd_nxt;
    logic [15:0]       r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt, w_err_set;
    logic [31:0]       r_dout, w_dout_nxt;
    logic              r_oe, w_oe_nxt;
    logic              r_dtack_n, w_dtack_n_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_rd, w_rd_nxt;
    logic [REG_AW-1:0] r_addr, w_addr_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;

    logic w_as, w_rs, w_ws, w_hit, w_idle_bus;

    assign w_as       = r_as_sy[1];
    assign w_rs       = r_rs_sy[1];
    assign w_ws       = r_ws_sy[1];
    assign w_hit      = (ADDR & ADDR_MASK) == BASE_ADDR;
    assign w_idle_bus = w_as & w_rs & w_ws;

    // Two-flop synchronizers; idle (high) out of reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_as_sy <= 2'b11;
            r_rs_sy <= 2'b11;
            r_ws_sy <= 2'b11;
        end else begin
            r_as_sy <= {r_as_sy[0], AS_N};
            r_rs_sy <= {r_rs_sy[0], RS_N};
            r_ws_sy <= {r_ws_sy[0], WS_N};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_is_rd   <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_dout    <= '0;
            r_oe      <= 1'b0;
            r_dtack_n <= 1'b1;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_is_rd   <= w_is_rd_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_dout    <= w_dout_nxt;
            r_oe      <= w_oe_nxt;
            r_dtack_n <= w_dtack_n_nxt;
            r_wr      <= w_wr_nxt;
            r_rd      <= w_rd_nxt;
            r_addr    <= w_addr_nxt;
            r_be      <= w_be_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_is_rd_nxt   = r_is_rd;
        w_cnt_nxt     = r_cnt;
        w_err_set     = 1'b0;
        w_dout_nxt    = r_dout;
        w_oe_nxt      = r_oe;
        w_dtack_n_nxt = r_dtack_n;
        w_wr_nxt      = 1'b0;
        w_rd_nxt      = 1'b0;
        w_addr_nxt    = r_addr;
        w_be_nxt      = r_be;
        w_wdata_nxt   = r_wdata;
        unique case (r_state)
            S_IDLE: begin
                if (!w_as) begin
                    if (!w_hit) begin
                        w_state_nxt = S_RELEASE;
                    end else if (!w_rs && !w_ws) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_RELEASE;
                    end else if (!w_ws || !w_rs) begin
                        // Bus lines are stable for the whole strobe.
                        w_addr_nxt  = ADDR[REG_AW+1:2];
                        w_be_nxt    = ~BE_N;
                        w_is_rd_nxt = !w_rs;
                        w_wr_nxt    = !w_ws;
                        w_rd_nxt    = !w_rs;
                        if (!w_ws) w_wdata_nxt = DIN;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (reg_ack || r_cnt == 16'(TIMEOUT - 1)) begin
                    if (r_is_rd) w_dout_nxt = reg_ack ? reg_rdata : ERR_DATA;
                    w_err_set     = !reg_ack;
                    w_cnt_nxt     = '0;
                    w_dtack_n_nxt = 1'b0;
                    w_oe_nxt      = r_is_rd;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_DONE: begin
                if (w_idle_bus) begin
                    w_dtack_n_nxt = 1'b1;
                    w_oe_nxt      = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (w_idle_bus) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Set wins over clear.
        w_err_nxt = w_err_set | (r_err & ~err_clr);
    end

    assign DOUT      = r_dout;
    assign DOUT_OE   = r_oe;
    assign DTACK_N   = r_dtack_n;
    assign reg_addr  = r_addr;
    assign reg_be    = r_be;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign err       = r_err;

endmodule
